// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e  : 2-bit controller state, also exported on o_state
//   TIMEOUT_DEF : default memory-wait watchdog limit in cycles
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } hz_state_e;

  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones, with a synchronous clear that
// takes priority over increment.
//   i_clk   : clock
//   i_reset : asynchronous active-low reset, counter to zero
//   i_inc   : increment this cycle (ignored once saturated)
//   i_clear : synchronous clear
//   o_cnt   : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_cnt <= '0;
    end else if (i_clear) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core. Resolves the hazards
// forwarding cannot cover (load-use, ID branch operands, data-memory wait,
// control-flow redirect) and drives per-stage enable/flush/bubble controls.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   RUN      | last cycle advanced the whole pipe normally
//   STALL    | last cycle held PC/IF-ID and bubbled ID/EX
//   MEM_WAIT | last cycle froze the whole pipe on a data-memory wait
//   FLUSH    | last cycle squashed IF/ID for a taken redirect
//
// Ports:
//   i_clk, i_reset         : clock, asynchronous active-low reset
//   i_id_*                 : ID-stage operand usage, branch flag, valid
//   i_id_ex_*, i_ex_mem_*  : destination/type of older instructions
//   i_redirect             : ID resolved a taken branch/jump
//   i_mem_req, i_mem_ack   : data-memory handshake in MEM
//   o_pc_en .. o_ex_en     : stage controls (combinational)
//   o_state                : registered state
//   o_stall_cnt/o_flush_cnt: saturating performance counters
//   o_mem_timeout          : sticky memory-wait watchdog flag
import core_pkg::*;

module hazard_controller #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_is_branch,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_ex_rd,
  input  logic             i_id_ex_reg_write,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_ex_mem_rd,
  input  logic             i_ex_mem_mem_read,
  input  logic             i_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_ex_en,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_mem_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  hz_state_e state_q, state_d;
  logic ex_hit, mem_hit;
  logic mem_wait, load_use, br_ex, br_mem, stall, flush_take;
  logic [WD_W-1:0] wd_cnt;

  // x0 is hardwired, so a zero destination never creates a dependency.
  assign ex_hit  = (i_id_ex_rd != 5'd0) &&
                   ((i_id_use_rs1 && (i_id_rs1 == i_id_ex_rd)) ||
                    (i_id_use_rs2 && (i_id_rs2 == i_id_ex_rd)));
  assign mem_hit = (i_ex_mem_rd != 5'd0) &&
                   ((i_id_use_rs1 && (i_id_rs1 == i_ex_mem_rd)) ||
                    (i_id_use_rs2 && (i_id_rs2 == i_ex_mem_rd)));

  assign mem_wait = i_mem_req && !i_mem_ack;
  assign load_use = i_id_valid && i_id_ex_mem_read && ex_hit;
  assign br_ex    = i_id_valid && i_id_is_branch && i_id_ex_reg_write && ex_hit;
  assign br_mem   = i_id_valid && i_id_is_branch && i_ex_mem_mem_read && mem_hit;
  assign stall    = load_use || br_ex || br_mem;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = RUN;
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_ex_en        = 1'b1;
    flush_take     = 1'b0;
    if (mem_wait) begin
      state_d    = MEM_WAIT;
      o_pc_en    = 1'b0;
      o_if_id_en = 1'b0;
      o_ex_en    = 1'b0;
    end else if (stall) begin
      // A redirect seen here is dropped; ID re-resolves it after the stall.
      state_d        = STALL;
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_redirect) begin
      state_d       = FLUSH;
      o_if_id_flush = 1'b1;
      flush_take    = 1'b1;
    end
    // Hold the pipe in a safe, bubbled state while reset is asserted.
    if (!i_reset) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      o_ex_en        = 1'b0;
      flush_take     = 1'b0;
    end
  end

  assign o_state = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (!o_pc_en),
    .i_clear (1'b0),
    .o_cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (flush_take),
    .i_clear (1'b0),
    .o_cnt   (o_flush_cnt)
  );

  sat_counter #(.W(WD_W)) u_wd_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (mem_wait),
    .i_clear (!mem_wait),
    .o_cnt   (wd_cnt)
  );

  // Set on the edge that completes the TIMEOUT-th consecutive wait cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_mem_timeout <= 1'b0;
    end else if (mem_wait && (wd_cnt >= WD_LAST)) begin
      o_mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [4:0]       i_id_rs1, i_id_rs2, i_id_ex_rd, i_ex_mem_rd;
  logic             i_id_use_rs1, i_id_use_rs2, i_id_is_branch, i_id_valid;
  logic             i_id_ex_reg_write, i_id_ex_mem_read, i_ex_mem_mem_read;
  logic             i_redirect, i_mem_req, i_mem_ack;
  logic             o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble, o_ex_en;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
  logic             o_mem_timeout;

  int n_vec = 0;
  int n_bad = 0;

  hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_id_rs1          (i_id_rs1),
    .i_id_rs2          (i_id_rs2),
    .i_id_use_rs1      (i_id_use_rs1),
    .i_id_use_rs2      (i_id_use_rs2),
    .i_id_is_branch    (i_id_is_branch),
    .i_id_valid        (i_id_valid),
    .i_id_ex_rd        (i_id_ex_rd),
    .i_id_ex_reg_write (i_id_ex_reg_write),
    .i_id_ex_mem_read  (i_id_ex_mem_read),
    .i_ex_mem_rd       (i_ex_mem_rd),
    .i_ex_mem_mem_read (i_ex_mem_mem_read),
    .i_redirect        (i_redirect),
    .i_mem_req         (i_mem_req),
    .i_mem_ack         (i_mem_ack),
    .o_pc_en           (o_pc_en),
    .o_if_id_en        (o_if_id_en),
    .o_if_id_flush     (o_if_id_flush),
    .o_id_ex_bubble    (o_id_ex_bubble),
    .o_ex_en           (o_ex_en),
    .o_state           (o_state),
    .o_stall_cnt       (o_stall_cnt),
    .o_flush_cnt       (o_flush_cnt),
    .o_mem_timeout     (o_mem_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0;
    i_id_is_branch = 1'b0; i_id_valid = 1'b0;
    i_id_ex_rd = 5'd0; i_id_ex_reg_write = 1'b0; i_id_ex_mem_read = 1'b0;
    i_ex_mem_rd = 5'd0; i_ex_mem_mem_read = 1'b0;
    i_redirect = 1'b0; i_mem_req = 1'b0; i_mem_ack = 1'b0;
  endtask

  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_en}
  task automatic ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble, o_ex_en}, {27'd0, exp});
  endtask

  // lw x<rd> in ID/EX, ID instruction reads rs1=<rd>
  task automatic set_load_use(input logic [4:0] rd);
    i_id_ex_rd = rd; i_id_ex_mem_read = 1'b1; i_id_ex_reg_write = 1'b1;
    i_id_valid = 1'b1; i_id_rs1 = rd; i_id_use_rs1 = 1'b1;
  endtask

  initial begin
    idle();
    i_reset = 1'b0;
    #3;
    ctl("reset_ctl", 5'b00110);
    chk("reset_state", o_state, 0);
    chk("reset_stall_cnt", o_stall_cnt, 0);
    chk("reset_flush_cnt", o_flush_cnt, 0);
    chk("reset_timeout", o_mem_timeout, 0);
    tick(); tick();
    i_reset = 1'b1;
    #1;
    ctl("run_ctl", 5'b11001);
    tick();
    chk("run_state", o_state, 0);
    chk("run_stall_cnt", o_stall_cnt, 0);

    // load-use: one stall cycle
    set_load_use(5'd5);
    #1;
    ctl("lu_ctl", 5'b00011);
    tick();
    chk("lu_state", o_state, 1);
    chk("lu_stall_cnt", o_stall_cnt, 1);
    idle();
    i_id_valid = 1'b1; i_id_rs1 = 5'd5; i_id_use_rs1 = 1'b1;
    i_ex_mem_rd = 5'd5; i_ex_mem_mem_read = 1'b1;
    #1;
    ctl("lu_after_ctl", 5'b11001);
    tick();
    chk("lu_after_state", o_state, 0);

    // branch after load: br_ex then br_mem
    idle();
    i_id_ex_rd = 5'd6; i_id_ex_mem_read = 1'b1; i_id_ex_reg_write = 1'b1;
    i_id_valid = 1'b1; i_id_is_branch = 1'b1;
    i_id_rs1 = 5'd6; i_id_use_rs1 = 1'b1; i_id_rs2 = 5'd0; i_id_use_rs2 = 1'b1;
    #1;
    ctl("bl1_ctl", 5'b00011);
    tick();
    chk("bl1_state", o_state, 1);
    i_id_ex_rd = 5'd0; i_id_ex_mem_read = 1'b0; i_id_ex_reg_write = 1'b0;
    i_ex_mem_rd = 5'd6; i_ex_mem_mem_read = 1'b1;
    #1;
    ctl("bl2_ctl", 5'b00011);
    tick();
    chk("bl2_state", o_state, 1);
    chk("bl_stall_cnt", o_stall_cnt, 3);
    i_ex_mem_rd = 5'd0; i_ex_mem_mem_read = 1'b0;
    #1;
    ctl("bl3_ctl", 5'b11001);
    tick();
    chk("bl3_state", o_state, 0);

    // branch after ALU op: one stall, EX/MEM ALU result is forwardable
    idle();
    i_id_ex_rd = 5'd7; i_id_ex_reg_write = 1'b1;
    i_id_valid = 1'b1; i_id_is_branch = 1'b1; i_id_rs2 = 5'd7; i_id_use_rs2 = 1'b1;
    #1;
    ctl("ba1_ctl", 5'b00011);
    tick();
    chk("ba_stall_cnt", o_stall_cnt, 4);
    i_id_ex_rd = 5'd0; i_id_ex_reg_write = 1'b0; i_ex_mem_rd = 5'd7;
    #1;
    ctl("ba2_ctl", 5'b11001);
    tick();

    // rd = 0 and non-hazard cases
    idle();
    set_load_use(5'd0);
    #1;
    chk("rd0_lu_pc_en", o_pc_en, 1);
    idle();
    i_id_valid = 1'b1; i_id_is_branch = 1'b1; i_id_use_rs1 = 1'b1;
    i_ex_mem_rd = 5'd0; i_ex_mem_mem_read = 1'b1;
    #1;
    chk("rd0_brmem_pc_en", o_pc_en, 1);
    idle();
    set_load_use(5'd5);
    i_id_use_rs1 = 1'b0;
    #1;
    chk("unused_rs_pc_en", o_pc_en, 1);
    i_id_use_rs1 = 1'b1; i_id_valid = 1'b0;
    #1;
    chk("invalid_id_pc_en", o_pc_en, 1);
    tick();
    chk("nohaz_stall_cnt", o_stall_cnt, 4);

    // memory wait with concurrent load-use
    idle();
    set_load_use(5'd9);
    i_mem_req = 1'b1;
    #1;
    ctl("mw_ctl", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mw_state", o_state, 2);
    end
    chk("mw_stall_cnt", o_stall_cnt, 7);
    i_mem_ack = 1'b1;
    #1;
    ctl("mw_ack_ctl", 5'b00011);
    tick();
    chk("mw_ack_state", o_state, 1);
    chk("mw_ack_stall_cnt", o_stall_cnt, 8);
    chk("mw_no_timeout", o_mem_timeout, 0);

    // redirect
    idle();
    i_redirect = 1'b1;
    #1;
    chk("rd_pc_en", o_pc_en, 1);
    chk("rd_flush", o_if_id_flush, 1);
    chk("rd_bubble", o_id_ex_bubble, 0);
    chk("rd_ex_en", o_ex_en, 1);
    tick();
    chk("rd_state", o_state, 3);
    chk("rd_flush_cnt", o_flush_cnt, 1);
    set_load_use(5'd3);
    #1;
    chk("rd_stall_flush", o_if_id_flush, 0);
    chk("rd_stall_pc_en", o_pc_en, 0);
    tick();
    chk("rd_stall_state", o_state, 1);
    chk("rd_stall_flush_cnt", o_flush_cnt, 1);
    idle();
    i_redirect = 1'b1; i_mem_req = 1'b1;
    #1;
    chk("rd_mw_flush", o_if_id_flush, 0);
    tick();
    chk("rd_mw_state", o_state, 2);
    chk("rd_mw_flush_cnt", o_flush_cnt, 1);
    chk("rd_mw_stall_cnt", o_stall_cnt, 10);

    // stall counter saturation (4-bit)
    idle();
    set_load_use(5'd4);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_sat", o_stall_cnt, 15);

    // watchdog: rises on the 4th consecutive wait edge, then sticky
    idle();
    i_mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("wd_3", o_mem_timeout, 0);
    tick();
    chk("wd_4", o_mem_timeout, 1);
    i_mem_ack = 1'b1;
    tick();
    chk("wd_sticky", o_mem_timeout, 1);
    chk("wd_sticky_state", o_state, 0);

    // async reset mid-wait
    i_mem_ack = 1'b0;
    tick(); tick();
    #2;
    i_reset = 1'b0;
    #1;
    ctl("ar_ctl", 5'b00110);
    chk("ar_state", o_state, 0);
    chk("ar_stall_cnt", o_stall_cnt, 0);
    chk("ar_flush_cnt", o_flush_cnt, 0);
    chk("ar_timeout", o_mem_timeout, 0);
    tick();
    i_mem_req = 1'b0;
    i_reset = 1'b1;
    #1;
    chk("ar_rel_state", o_state, 0);
    ctl("ar_rel_ctl", 5'b11001);
    tick();
    chk("ar_run_state", o_state, 0);
    chk("ar_run_timeout", o_mem_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
